seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It holds a frame-coherent shadow copy of the displayed value and steps one shared hex-to-segment decoder across the digits. Each digit slot gets a blanking guard interval to suppress ghosting, and leading-zero suppression is optional. The block sits between the value producers (counters, BCD converters) and the board display pins.

## Interface
- NUM_DIGITS, 4, digit count (≥2)
- CLK_DIV, 50000, clock cycles per digit slot (≥2)
- BLANK_CYCLES, 500, guard cycles at the start of each slot with all anodes off (0 ≤ BLANK_CYCLES < CLK_DIV)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en_i  in  1  scan enable
- value_i  in  4*NUM_DIGITS  nibble k is digit k; digit 0 is the rightmost digit
- dp_i  in  NUM_DIGITS  decimal point per digit, active-high
- load_i  in  1  single-cycle strobe that captures value_i/dp_i as a pending update
- lzs_i  in  1  leading-zero suppression enable, sampled at apply time
- load_ack_o  out  1  one-cycle pulse when a pending update is applied to the shadow register
- frame_o  out  1  one-cycle pulse on each wrap from digit NUM_DIGITS-1 to digit 0
- an_o  out  NUM_DIGITS  anode drives, active-low, at most one bit low at a time
- seg_o  out  8  {dp,g,f,e,d,c,b,a}, active-high

## Operation
- Registers:
  - shadow (value, dp, lzs mask)
  - pending (value, dp, valid)
  - digit index idx
  - slot counter cnt (0..CLK_DIV-1)
  - FSM state
- FSM states:
  - IDLE: an_o all 1, seg_o 0. Go to BLANK when en_i=1, with idx=0 and cnt=0.
  - BLANK: an_o all 1. When cnt reaches BLANK_CYCLES-1, go to SHOW. With BLANK_CYCLES=0, BLANK is skipped and the slot starts directly in SHOW.
  - SHOW: an_o[idx]=0, seg_o = decode(shadow nibble idx) with bit 7 = shadow dp[idx]. When cnt reaches CLK_DIV-1, set cnt=0, advance idx modulo NUM_DIGITS, and go to BLANK.
  - Any state with en_i=0 goes to IDLE on the next cycle.
- Update rules:
  - load_i=1 writes pending and sets valid. A later load before apply overwrites pending; only the applied update is acknowledged.
  - Apply happens at a frame boundary (the SHOW→BLANK transition where idx wraps to 0), or on any cycle while in IDLE. Apply copies pending to shadow, clears valid, and pulses load_ack_o.
  - If load_i coincides with an apply cycle, the incoming value_i/dp_i is applied directly on that cycle (bypass) and acknowledged.
- Leading-zero suppression:
  - The mask is computed at apply time.
  - Scanning from digit NUM_DIGITS-1 downward, each zero nibble is blanked until the first nonzero nibble. Digit 0 is never blanked.
  - A blanked digit shows seg_o 0 (dp still honoured) with its anode asserted.
- Decode map for nibbles 0–F, bits {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.

## Timing
- Reset values:
  - Outputs: an_o all 1, seg_o 0, load_ack_o 0, frame_o 0.
  - Registers: state IDLE, idx 0, cnt 0, shadow 0, pending valid 0.
- an_o and seg_o are registered and change on the same edge, one cycle after the state/idx update.
- Frame period is NUM_DIGITS*CLK_DIV cycles. Each digit is lit for CLK_DIV-BLANK_CYCLES cycles.
- frame_o and load_ack_o assert in the cycle the wrap is registered and are coincident when an update is applied at a wrap.
- Apply latency:
  - While scanning: at most one frame.
  - In IDLE: 1 cycle.
- Deasserting en_i mid-slot: anodes go off within 1 cycle and the next enable restarts at digit 0, BLANK.
- rst_n asserted mid-frame clears everything asynchronously, including a pending update, which is dropped with no ack.

## Structure
- Package seg7_pkg holds:
  - the 16-entry segment constant map
  - the segment-bit index constants (SEG_A..SEG_G, SEG_DP)
  - the FSM state enum {IDLE, BLANK, SHOW}
- Sub-module seg7_decode: purely combinational, nibble in, 7 segment bits out, using the package map. Instantiated once and shared across digits.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
- Reset, then en_i=1, load value 0x1234 while in IDLE → load_ack_o 1 cycle later.
  - Digits lit in order 0..3 with seg {g..a} 1100110, 1001111, 1011011, 0000110.
  - Each digit lit 6 of every 8 cycles, frame_o every 32 cycles.
- Load 0xABCD mid-frame at idx=1 → display unchanged until wrap; load_ack_o coincides with frame_o; next frame shows D, C, b, A.
- Two loads 0x1111 then 0x2222 in the same frame → one ack; 0x2222 displayed.
- lzs_i=1 with value 0x0050 → digits 3 and 2 seg 0 with anode still pulsed; digit 1 shows 5, digit 0 shows 0.
- load_i on the exact wrap cycle with 0x9999 → applied and acked that cycle; next frame shows 9999.
- rst_n low during SHOW of digit 2 with a pending load → an_o all 1 immediately, shadow 0, and no ack after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit segment bus {dp,g,f,e,d,c,b,a}
//   SEG_MAP              : hex nibble -> {g,f,e,d,c,b,a}, active-high
//   state_e              : scan FSM states
package seg7_pkg;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Entry n holds the {g..a} pattern for nibble n (first listed entry is index 15).
   localparam logic [15:0][6:0] SEG_MAP = {
      7'b1110001,  // F
      7'b1111001,  // E
      7'b1011110,  // d
      7'b0111001,  // C
      7'b1111100,  // b
      7'b1110111,  // A
      7'b1101111,  // 9
      7'b1111111,  // 8
      7'b0000111,  // 7
      7'b1111101,  // 6
      7'b1101101,  // 5
      7'b1100110,  // 4
      7'b1001111,  // 3
      7'b1011011,  // 2
      7'b0000110,  // 1
      7'b0111111   // 0
   };

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment decoder.
//   nibble : hex digit 0..F
//   seg    : {g,f,e,d,c,b,a}, active-high
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   logic [6:0] row;

   assign row = SEG_MAP[nibble];

   assign seg[SEG_A] = row[SEG_A];
   assign seg[SEG_B] = row[SEG_B];
   assign seg[SEG_C] = row[SEG_C];
   assign seg[SEG_D] = row[SEG_D];
   assign seg[SEG_E] = row[SEG_E];
   assign seg[SEG_F] = row[SEG_F];
   assign seg[SEG_G] = row[SEG_G];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : scan enable
//   value_i      : nibble k drives digit k (digit 0 rightmost)
//   dp_i         : decimal point per digit
//   load_i       : strobe capturing value_i/dp_i as a pending update
//   lzs_i        : leading-zero suppression, sampled when an update is applied
//   load_ack_o   : pulse when an update reaches the shadow register
//   frame_o      : pulse on each wrap from the last digit back to digit 0
//   an_o         : anode drives, active-low
//   seg_o        : {dp,g,f,e,d,c,b,a}, active-high
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic [NUM_DIGITS-1:0]     dp_i,
   input  logic                      load_i,
   input  logic                      lzs_i,
   output logic                      load_ack_o,
   output logic                      frame_o,
   output logic [NUM_DIGITS-1:0]     an_o,
   output logic [7:0]                seg_o
);

   localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
   localparam int unsigned CNT_W     = $clog2(CLK_DIV);
   localparam bit          HAS_BLANK = (BLANK_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam state_e SLOT_START = HAS_BLANK ? BLANK : SHOW;

   state_e                         state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           wrap;

   logic [NUM_DIGITS-1:0][3:0]     shadow_val_q;
   logic [NUM_DIGITS-1:0]          shadow_dp_q, shadow_mask_q;
   logic [NUM_DIGITS-1:0][3:0]     pend_val_q;
   logic [NUM_DIGITS-1:0]          pend_dp_q;
   logic                           pend_valid_q;

   logic                           apply_cyc, do_apply, lzs_run;
   logic [NUM_DIGITS-1:0][3:0]     apply_val;
   logic [NUM_DIGITS-1:0]          apply_dp, apply_mask;

   logic [NUM_DIGITS-1:0]          an_q, an_d;
   logic [7:0]                     seg_q, seg_d;
   logic                           ack_q, frame_q;
   logic [6:0]                     dec_seg;

   // Scan sequencing: cnt spans the whole slot, BLANK covers its first BLANK_CYCLES counts.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wrap    = 1'b0;
      if (!en_i) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = SLOT_START;
               idx_d   = '0;
               cnt_d   = '0;
            end
            BLANK: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == BLANK_LAST) state_d = SHOW;
            end
            SHOW: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = SLOT_START;
                  if (idx_q == IDX_LAST) begin
                     idx_d = '0;
                     wrap  = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A strobe landing on an apply cycle bypasses the pending register.
   assign apply_cyc = (state_q == IDLE) || wrap;
   assign do_apply  = apply_cyc && (load_i || pend_valid_q);
   assign apply_val = load_i ? value_i : pend_val_q;
   assign apply_dp  = load_i ? dp_i    : pend_dp_q;

   // Blank zeros from the top digit down until the first nonzero one; digit 0 always shows.
   always_comb begin
      apply_mask = '0;
      lzs_run    = lzs_i;
      for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
         if (lzs_run && (apply_val[k] == 4'd0)) apply_mask[k] = 1'b1;
         else lzs_run = 1'b0;
      end
   end

   seg7_decode u_decode (
      .nibble (shadow_val_q[idx_q]),
      .seg    (dec_seg)
   );

   // Gating by en_i turns the anodes off on the very edge that samples the disable.
   always_comb begin
      an_d  = '1;
      seg_d = '0;
      if (en_i && (state_q == SHOW)) begin
         an_d[idx_q] = 1'b0;
         if (!shadow_mask_q[idx_q]) seg_d[SEG_G:SEG_A] = dec_seg;
         seg_d[SEG_DP] = shadow_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         shadow_val_q  <= '0;
         shadow_dp_q   <= '0;
         shadow_mask_q <= '0;
         pend_val_q    <= '0;
         pend_dp_q     <= '0;
         pend_valid_q  <= 1'b0;
         an_q          <= '1;
         seg_q         <= '0;
         ack_q         <= 1'b0;
         frame_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         ack_q   <= do_apply;
         frame_q <= wrap;
         if (do_apply) begin
            shadow_val_q  <= apply_val;
            shadow_dp_q   <= apply_dp;
            shadow_mask_q <= apply_mask;
         end
         if (load_i && !apply_cyc) begin
            pend_val_q   <= value_i;
            pend_dp_q    <= dp_i;
            pend_valid_q <= 1'b1;
         end else if (do_apply) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   assign an_o       = an_q;
   assign seg_o      = seg_q;
   assign load_ack_o = ack_q;
   assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 guard cycles).
// The reference model tracks time since enable and derives the lit digit, frame
// wraps and update application from plain arithmetic.
module tb_seg7_scan_ctrl;

   localparam int unsigned ND    = 4;
   localparam int unsigned CD    = 8;
   localparam int unsigned BC    = 2;
   localparam int unsigned FRAME = ND * CD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        load;
   logic        lzs;
   logic        ack;
   logic        frame;
   logic [3:0]  an;
   logic [7:0]  seg;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .CLK_DIV      (CD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en),
      .value_i    (value),
      .dp_i       (dp),
      .load_i     (load),
      .lzs_i      (lzs),
      .load_ack_o (ack),
      .frame_o    (frame),
      .an_o       (an),
      .seg_o      (seg)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic [3:0]  m_val  [ND];
   bit          m_dp   [ND];
   bit          m_mask [ND];
   bit          m_pend_valid;
   logic [15:0] m_pend_val;
   logic [3:0]  m_pend_dp;
   bit          m_run;
   int          m_t;
   logic [3:0]  e_an;
   logic [7:0]  e_seg;
   logic        e_ack;
   logic        e_frame;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s at %0t: observed %h, expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "/an"},    {4'h0, an},     {4'h0, e_an});
      check({tag, "/seg"},   seg,            e_seg);
      check({tag, "/ack"},   {7'h0, ack},    {7'h0, e_ack});
      check({tag, "/frame"}, {7'h0, frame},  {7'h0, e_frame});
   endtask

   task automatic model_reset();
      for (int k = 0; k < ND; k++) begin
         m_val[k]  = 4'h0;
         m_dp[k]   = 1'b0;
         m_mask[k] = 1'b0;
      end
      m_pend_valid = 1'b0;
      m_pend_val   = '0;
      m_pend_dp    = '0;
      m_run        = 1'b0;
      m_t          = 0;
      e_an         = 4'hF;
      e_seg        = 8'h00;
      e_ack        = 1'b0;
      e_frame      = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs present at that edge.
   task automatic model_edge();
      int          s, d, h;
      bit          show, wrap, apply_cyc, do_apply;
      logic [15:0] v;
      logic [3:0]  dps;
      s    = m_t;
      d    = (s / CD) % ND;
      show = en && m_run && ((s % CD) >= BC);
      e_an  = 4'hF;
      e_seg = 8'h00;
      if (show) begin
         e_an[d] = 1'b0;
         e_seg   = {m_dp[d], m_mask[d] ? 7'h00 : hex7(m_val[d])};
      end
      wrap      = en && m_run && ((s % FRAME) == FRAME - 1);
      apply_cyc = !m_run || wrap;
      do_apply  = apply_cyc && (load || m_pend_valid);
      e_ack     = do_apply;
      e_frame   = wrap;
      if (do_apply) begin
         v   = load ? value : m_pend_val;
         dps = load ? dp : m_pend_dp;
         h   = -1;
         for (int k = 0; k < ND; k++) if (v[4*k +: 4] != 4'h0) h = k;
         for (int k = 0; k < ND; k++) begin
            m_val[k]  = v[4*k +: 4];
            m_dp[k]   = dps[k];
            m_mask[k] = lzs && (k > h) && (k != 0);
         end
      end
      if (load && !apply_cyc) begin
         m_pend_val   = value;
         m_pend_dp    = dp;
         m_pend_valid = 1'b1;
      end else if (do_apply) begin
         m_pend_valid = 1'b0;
      end
      if (!en) begin
         m_run = 1'b0;
         m_t   = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_t   = 0;
      end else begin
         m_t++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outs("cycle");
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the next edge will see the given position within the frame.
   task automatic advance_to(input int phase);
      for (int i = 0; (i < 2 * FRAME) && ((m_t % FRAME) != phase); i++) step();
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] p);
      load  = 1'b1;
      value = v;
      dp    = p;
      step();
      load  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      load  = 1'b0;
      lzs   = 1'b0;
      value = '0;
      dp    = '0;
      model_reset();

      #2 rst_n = 1'b0;
      #1 check_outs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Enable and load 0x1234 from IDLE: ack one cycle later, then steady scanning.
      en = 1'b1;
      pulse_load(16'h1234, 4'b0000);
      run(2 * FRAME + 6);

      // Mid-frame load at digit 1 waits for the wrap.
      advance_to(CD + 2);
      pulse_load(16'hABCD, 4'b0101);
      run(2 * FRAME);

      // Two loads in one frame: only the second is applied.
      advance_to(3);
      pulse_load(16'h1111, 4'b0000);
      run(5);
      pulse_load(16'h2222, 4'b1000);
      run(2 * FRAME);

      // Leading-zero suppression of 0x0050.
      lzs = 1'b1;
      advance_to(5);
      pulse_load(16'h0050, 4'b0100);
      run(2 * FRAME);
      lzs = 1'b0;

      // Load on the exact wrap edge.
      advance_to(FRAME - 1);
      pulse_load(16'h9999, 4'b0000);
      run(FRAME + 2);

      // Disable mid-slot, load while idle, re-enable.
      advance_to(12);
      en = 1'b0;
      run(3);
      pulse_load(16'h5A0F, 4'b0011);
      en = 1'b1;
      run(FRAME + 4);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         en    = ($urandom_range(0, 29) != 0);
         load  = ($urandom_range(0, 11) == 0);
         value = 16'($urandom);
         if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
         dp    = 4'($urandom);
         lzs   = 1'($urandom);
         step();
      end
      load = 1'b0;
      lzs  = 1'b0;
      en   = 1'b1;
      run(3);

      // Reset during SHOW of digit 2 with an update pending: dropped, no ack.
      pulse_load(16'h8765, 4'b0000);
      advance_to(2 * CD + 3);
      pulse_load(16'h4321, 4'b1111);
      rst_n = 1'b0;
      model_reset();
      #1 check_outs("mid_reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run(2 * FRAME + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
